// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//   Circular byte queue between instruction fetch and the decoder. Fetch pushes
//   one byte per cycle; the decoder peeks up to MAX_POP bytes and pops
//   0..MAX_POP of them per cycle. A synchronous flush empties the queue
//   (taken branch / jump). Sticky flags record rejected pushes and pops.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   queue_flush  in   discard all entries, clear error flags (highest priority)
//   queue_push   in   enqueue queue_in this cycle
//   queue_in     in   byte to enqueue
//   queue_pop    in   number of bytes to dequeue this cycle
//   queue_out    out  peek window, entry k (k=0 oldest) at [k*DATA_W +: DATA_W]
//   queue_count  out  occupancy 0..DEPTH
//   queue_valid  out  bit k set iff k < queue_count
//   full / empty out  occupancy == DEPTH / == 0
//   overflow     out  sticky, set by a rejected push
//   underflow    out  sticky, set by a rejected pop
module inst_prefetch_queue #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_POP = 3,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned POP_W  = $clog2(MAX_POP + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      queue_flush,
  input  logic                      queue_push,
  input  logic [DATA_W-1:0]         queue_in,
  input  logic [POP_W-1:0]          queue_pop,
  output logic [MAX_POP*DATA_W-1:0] queue_out,
  output logic [CNT_W-1:0]          queue_count,
  output logic [MAX_POP-1:0]        queue_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr_s;
  logic [PTR_W-1:0]  r_ptr_e;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_pop_ok;
  logic [CNT_W-1:0]  w_pop_n;
  logic              w_push_ok;

  // Pop is all-or-nothing. Push legality uses the post-pop occupancy so a full
  // queue still accepts a byte in a cycle that also pops.
  always_comb begin
    w_pop_ok  = (32'(queue_pop) <= 32'(r_count)) && (32'(queue_pop) <= MAX_POP);
    w_pop_n   = w_pop_ok ? CNT_W'(queue_pop) : '0;
    w_push_ok = queue_push && ((r_count - w_pop_n) < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr_s     <= '0;
      r_ptr_e     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (queue_flush) begin
      r_ptr_s     <= '0;
      r_ptr_e     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Pointers wrap modulo DEPTH through natural overflow.
      r_ptr_s <= r_ptr_s + PTR_W'(w_pop_n);
      if (w_push_ok) begin
        r_ptr_e <= r_ptr_e + 1'b1;
      end
      r_count <= r_count - w_pop_n + CNT_W'(w_push_ok);
      if (!w_pop_ok) begin
        r_underflow <= 1'b1;
      end
      if (queue_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (!queue_flush && w_push_ok) begin
      r_mem[r_ptr_e] <= queue_in;
    end
  end

  always_comb begin
    queue_out   = '0;
    queue_valid = '0;
    for (int k = 0; k < int'(MAX_POP); k++) begin
      queue_out[k*DATA_W +: DATA_W] = r_mem[r_ptr_s + PTR_W'(k)];
      queue_valid[k]                = CNT_W'(k) < r_count;
    end
  end

  assign queue_count = r_count;
  assign full        = (r_count == CNT_W'(DEPTH));
  assign empty       = (r_count == '0);
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int MAX_POP = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        queue_flush;
  logic        queue_push;
  logic [7:0]  queue_in;
  logic [1:0]  queue_pop;
  logic [23:0] queue_out;
  logic [4:0]  queue_count;
  logic [2:0]  queue_valid;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  inst_prefetch_queue #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .MAX_POP (MAX_POP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .queue_flush (queue_flush),
    .queue_push  (queue_push),
    .queue_in    (queue_in),
    .queue_pop   (queue_pop),
    .queue_out   (queue_out),
    .queue_count (queue_count),
    .queue_valid (queue_valid),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain byte queue plus sticky flags.
  byte unsigned m_q[$];
  bit           m_ovf;
  bit           m_udf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_model();
    int         n;
    logic [2:0] v;
    n = m_q.size();
    v = '0;
    for (int k = 0; k < MAX_POP; k++) v[k] = (k < n);
    check_eq("count", 32'(queue_count), 32'(n));
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("full", 32'(full), 32'(n == DEPTH));
    check_eq("valid", 32'(queue_valid), 32'(v));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("underflow", 32'(underflow), 32'(m_udf));
    for (int k = 0; k < MAX_POP; k++) begin
      if (k < n) check_eq($sformatf("lane%0d", k), 32'(queue_out[k*8 +: 8]), 32'(m_q[k]));
    end
  endtask

  // Called at a negedge: drives inputs, clocks once, updates model, checks.
  task automatic step(input bit fl, input bit pu, input logic [7:0] d, input int po);
    queue_flush = fl;
    queue_push  = pu;
    queue_in    = d;
    queue_pop   = 2'(po);
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      if (po <= m_q.size() && po <= MAX_POP) begin
        for (int i = 0; i < po; i++) void'(m_q.pop_front());
      end else begin
        m_udf = 1'b1;
      end
      if (pu) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    queue_flush = 1'b0;
    queue_push  = 1'b0;
    queue_pop   = 2'd0;
    check_model();
  endtask

  initial begin
    reset_n     = 1'b0;
    queue_flush = 1'b0;
    queue_push  = 1'b0;
    queue_in    = 8'h00;
    queue_pop   = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_count", 32'(queue_count), 32'd0);
    check_eq("rst_valid", 32'(queue_valid), 32'd0);
    check_model();
    reset_n = 1'b1;

    // Basic push / peek / multi-pop.
    step(0, 1, 8'hA9, 0);
    step(0, 1, 8'h05, 0);
    step(0, 1, 8'h8D, 0);
    check_eq("tp1_out", 32'(queue_out), 32'h8D05A9);
    check_eq("tp1_valid", 32'(queue_valid), 32'b111);
    step(0, 0, 8'h00, 2);
    check_eq("tp1_pop_lane0", 32'(queue_out[7:0]), 32'h8D);
    check_eq("tp1_pop_count", 32'(queue_count), 32'd1);

    // Fill, overflow, push into full with simultaneous pop.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i), 0);
    check_eq("tp2_full", 32'(full), 32'd1);
    step(0, 1, 8'hFF, 0);
    check_eq("tp2_ovf", 32'(overflow), 32'd1);
    check_eq("tp2_cnt16", 32'(queue_count), 32'd16);
    step(0, 1, 8'h10, 3);
    check_eq("tp2_cnt14", 32'(queue_count), 32'd14);
    check_eq("tp2_last", 32'(m_q[$]), 32'h10);
    for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1);
    check_eq("tp2_tail_lane2", 32'(queue_out[23:16]), 32'h10);

    // Underflow is all-or-nothing; pop 0 on empty is harmless.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h21, 0);
    step(0, 1, 8'h22, 0);
    step(0, 0, 8'h00, 3);
    check_eq("tp3_udf", 32'(underflow), 32'd1);
    check_eq("tp3_cnt", 32'(queue_count), 32'd2);
    check_eq("tp3_win", 32'(queue_out[15:0]), 32'h2221);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check_eq("tp3_nofl", 32'(underflow), 32'd0);

    // Wrap-around: read pointer to 14, then push across the boundary.
    for (int i = 0; i < 14; i++) step(0, 1, 8'hC0 + 8'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 3);
    step(0, 0, 8'h00, 2);
    check_eq("tp4_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h11 + 8'(i), 0);
    check_eq("tp4_win", 32'(queue_out), 32'h131211);
    step(0, 0, 8'h00, 3);
    check_eq("tp4_lane0", 32'(queue_out[7:0]), 32'h14);

    // Flush beats simultaneous push/pop and clears flags.
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 2);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h30 + 8'(i), 0);
    check_eq("tp5_udf_set", 32'(underflow), 32'd1);
    step(1, 1, 8'h55, 1);
    check_eq("tp5_cnt", 32'(queue_count), 32'd0);
    check_eq("tp5_empty", 32'(empty), 32'd1);
    check_eq("tp5_udf_clr", 32'(underflow), 32'd0);
    step(0, 0, 8'h00, 0);
    check_eq("tp5_still_empty", 32'(queue_count), 32'd0);

    // Asynchronous reset mid-stream, off the clock edge.
    for (int i = 0; i < 6; i++) step(0, 1, 8'h60 + 8'(i), 0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("ar_count", 32'(queue_count), 32'd0);
    check_eq("ar_empty", 32'(empty), 32'd1);
    check_eq("ar_valid", 32'(queue_valid), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    @(negedge clk);
    step(0, 1, 8'h42, 0);
    check_eq("ar_first", 32'(queue_out[7:0]), 32'h42);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit fl, pu;
      int po;
      fl = ($urandom_range(0, 99) == 0);
      pu = ($urandom_range(0, 99) < 60);
      po = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0 && po > m_q.size()) po = m_q.size() > 3 ? 3 : m_q.size();
      step(fl, pu, 8'($urandom), po);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
